// File: rtl/sim_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : sim_tick_gen
// Brief    : Multi-channel programmable tick generator with free-run, freeze
//            and counted single-step control. Optional macro SIM_TICK_CNT_EN
//            adds a 32-bit channel-0 tick counter output (TICK_CNT).
// Revision : 1.0 - initial release
// ============================================================================
module sim_tick_gen #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 50000,
    parameter int STEP_W    = 8
) (
    input  logic                                       CLK_50MHZ,
    input  logic                                       RST,
    input  logic                                       RUN_EN,
    input  logic                                       CFG_WE,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] CFG_CH,
    input  logic [DIV_W-1:0]                           CFG_DIV,
    input  logic                                       STEP_REQ,
    input  logic [STEP_W-1:0]                          STEP_COUNT,
    output logic                                       STEP_BUSY,
    output logic [NUM_CH-1:0]                          TICK,
    output logic [NUM_CH-1:0]                          SIM_CLK,
`ifdef SIM_TICK_CNT_EN
    output logic [31:0]                                TICK_CNT,
`endif
    output logic [7:0]                                 LED
);

    localparam int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0]  c_DIV_INIT = DIV_W'(DIV_RESET);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t              r_state;
    logic [STEP_W-1:0]   r_remaining;
    logic                r_stepBusy;
    logic                r_runEnQ;

    logic [DIV_W-1:0]    r_cnt [NUM_CH];
    logic [DIV_W-1:0]    r_div [NUM_CH];
    logic [NUM_CH-1:0]   r_tick;
    logic [NUM_CH-1:0]   r_simClk;

    logic [NUM_CH-1:0]   w_term;
    logic [NUM_CH-1:0]   w_cfgHit;
    logic                w_enable;
    logic                w_tick0Now;

    assign w_enable = (r_state == S_RUN) || (r_state == S_STEP);

    // Terminal-count and config-hit decode per channel; a divide of 0 behaves as 1.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [DIV_W-1:0] w_divEff;
            assign w_divEff    = (r_div[i] == '0) ? DIV_W'(1) : r_div[i];
            assign w_term[i]   = (r_cnt[i] == (w_divEff - DIV_W'(1)));
            assign w_cfgHit[i] = CFG_WE && (CFG_CH == CH_W'(i));
        end
    endgenerate

    // Channel 0 tick being registered on this edge; a colliding config write suppresses it.
    assign w_tick0Now = w_enable && w_term[0] && !w_cfgHit[0];

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
                r_div[i] <= c_DIV_INIT;
            end
            r_tick   <= '0;
            r_simClk <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfgHit[i]) begin
                    r_div[i]  <= CFG_DIV;
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b0;
                end else if (w_enable) begin
                    if (w_term[i]) begin
                        r_cnt[i]    <= '0;
                        r_tick[i]   <= 1'b1;
                        r_simClk[i] <= ~r_simClk[i];
                    end else begin
                        r_cnt[i]  <= r_cnt[i] + DIV_W'(1);
                        r_tick[i] <= 1'b0;
                    end
                end else begin
                    r_tick[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_stepBusy  <= 1'b0;
            r_runEnQ    <= 1'b0;
        end else begin
            r_runEnQ <= RUN_EN;
            case (r_state)
                S_IDLE: begin
                    if (RUN_EN) begin
                        r_state <= S_RUN;
                    end else if (STEP_REQ && (STEP_COUNT != '0)) begin
                        r_state     <= S_STEP;
                        r_remaining <= STEP_COUNT;
                        r_stepBusy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!RUN_EN) begin
                        r_state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (RUN_EN) begin
                        r_state     <= S_RUN;
                        r_remaining <= '0;
                        r_stepBusy  <= 1'b0;
                    end else if (w_tick0Now) begin
                        // Busy falls on the same edge that registers the final tick.
                        if (r_remaining == STEP_W'(1)) begin
                            r_state     <= S_IDLE;
                            r_remaining <= '0;
                            r_stepBusy  <= 1'b0;
                        end else begin
                            r_remaining <= r_remaining - STEP_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_remaining <= '0;
                    r_stepBusy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIM_TICK_CNT_EN
    logic [31:0] r_tickCnt;

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_tickCnt <= '0;
        end else if (w_tick0Now) begin
            r_tickCnt <= r_tickCnt + 32'd1;
        end
    end

    assign TICK_CNT = r_tickCnt;
`endif

    assign TICK      = r_tick;
    assign SIM_CLK   = r_simClk;
    assign STEP_BUSY = r_stepBusy;
    assign LED       = {5'b00000, r_runEnQ, r_stepBusy, r_simClk[0]};

endmodule
`default_nettype wire

// File: tb/tb_sim_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_tick_gen
// Brief    : Scenario bench for sim_tick_gen with a modular-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_tick_gen;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 16;
    localparam int DIV_RESET = 4;
    localparam int STEP_W    = 8;

    logic              CLK_50MHZ = 1'b0;
    logic              RST = 1'b1;
    logic              RUN_EN = 1'b0;
    logic              CFG_WE = 1'b0;
    logic [1:0]        CFG_CH = '0;
    logic [DIV_W-1:0]  CFG_DIV = '0;
    logic              STEP_REQ = 1'b0;
    logic [STEP_W-1:0] STEP_COUNT = '0;
    logic              STEP_BUSY;
    logic [NUM_CH-1:0] TICK;
    logic [NUM_CH-1:0] SIM_CLK;
    logic [7:0]        LED;
`ifdef SIM_TICK_CNT_EN
    logic [31:0]       TICK_CNT;
`endif

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    sim_tick_gen #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET),
        .STEP_W    (STEP_W)
    ) dut (
        .CLK_50MHZ  (CLK_50MHZ),
        .RST        (RST),
        .RUN_EN     (RUN_EN),
        .CFG_WE     (CFG_WE),
        .CFG_CH     (CFG_CH),
        .CFG_DIV    (CFG_DIV),
        .STEP_REQ   (STEP_REQ),
        .STEP_COUNT (STEP_COUNT),
        .STEP_BUSY  (STEP_BUSY),
        .TICK       (TICK),
        .SIM_CLK    (SIM_CLK),
`ifdef SIM_TICK_CNT_EN
        .TICK_CNT   (TICK_CNT),
`endif
        .LED        (LED)
    );

    // Reference model: phase = ticks-since-last modulo period; mode 0 idle, 1 run, 2 step.
    int                mCnt [NUM_CH];
    int                mDiv [NUM_CH];
    logic [NUM_CH-1:0] mTick;
    logic [NUM_CH-1:0] mSim;
    int                mMode;
    int                mLeft;
    logic              mBusy;
    logic              mRunQ;
    logic [31:0]       mTickCnt;

    int vectors = 0;
    int miscompares = 0;

    task automatic modelEdge();
        logic en;
        int   period;
        if (RST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mCnt[c] = 0;
                mDiv[c] = DIV_RESET;
            end
            mTick = '0; mSim = '0; mMode = 0; mLeft = 0;
            mBusy = 1'b0; mRunQ = 1'b0; mTickCnt = '0;
        end else begin
            en = (mMode != 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if (CFG_WE && (int'(CFG_CH) == c)) begin
                    mDiv[c]  = int'(CFG_DIV);
                    mCnt[c]  = 0;
                    mTick[c] = 1'b0;
                end else if (en) begin
                    period   = (mDiv[c] == 0) ? 1 : mDiv[c];
                    mCnt[c]  = (mCnt[c] + 1) % period;
                    mTick[c] = (mCnt[c] == 0);
                    if (mTick[c]) mSim[c] = ~mSim[c];
                end else begin
                    mTick[c] = 1'b0;
                end
            end
            if (mTick[0]) mTickCnt = mTickCnt + 32'd1;
            case (mMode)
                0: if (RUN_EN) mMode = 1;
                   else if (STEP_REQ && STEP_COUNT != 0) begin
                       mMode = 2; mLeft = int'(STEP_COUNT); mBusy = 1'b1;
                   end
                1: if (!RUN_EN) mMode = 0;
                default: if (RUN_EN) begin
                       mMode = 1; mLeft = 0; mBusy = 1'b0;
                   end else if (mTick[0]) begin
                       mLeft--;
                       if (mLeft == 0) begin mMode = 0; mBusy = 1'b0; end
                   end
            endcase
            mRunQ = RUN_EN;
        end
    endtask

    task automatic clk1();
        @(posedge CLK_50MHZ);
        modelEdge();
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) clk1();
        vectors++;
        if ({STEP_BUSY, TICK, SIM_CLK, LED} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", {STEP_BUSY, TICK, SIM_CLK, LED});
        end
    endtask

    task automatic test_freerun();
        int firstTick = -1;
        RUN_EN = 1'b1;
        RST    = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            clk1();
            if (TICK[0] && firstTick < 0) firstTick = cyc;
            vectors++;
            if ({STEP_BUSY, TICK, SIM_CLK, LED} !== {mBusy, mTick, mSim, 5'b0, mRunQ, mBusy, mSim[0]}) begin
                miscompares++;
                $display("FAIL freerun cyc=%0d got=%h want=%h", cyc, {STEP_BUSY, TICK, SIM_CLK, LED},
                         {mBusy, mTick, mSim, 5'b0, mRunQ, mBusy, mSim[0]});
            end
        end
        vectors++;
        if (firstTick !== 5) begin
            miscompares++;
            $display("FAIL freerun_first_tick got=%0d want=5", firstTick);
        end
    endtask

    task automatic test_cfg_div();
        CFG_WE = 1'b1; CFG_CH = 2'd1; CFG_DIV = 16'd0;
        clk1();
        CFG_CH = 2'd2; CFG_DIV = 16'd1;
        clk1();
        CFG_WE = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            clk1();
            vectors++;
            if (TICK[2:1] !== 2'b11 || {TICK, SIM_CLK} !== {mTick, mSim}) begin
                miscompares++;
                $display("FAIL cfg_div cyc=%0d got=%h want=%h", cyc, {TICK, SIM_CLK}, {mTick, mSim});
            end
        end
    endtask

    task automatic test_step();
        int pulses = 0;
        int lastAt = -1;
        int gapBad = 0;
        int cyc;
        RUN_EN = 1'b0;
        clk1();
        CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_DIV = 16'd3;
        clk1();
        CFG_WE = 1'b0;
        STEP_REQ = 1'b1; STEP_COUNT = 8'd5;
        clk1();
        STEP_REQ = 1'b0;
        vectors++;
        if (STEP_BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL step_busy_rise got=%b want=1", STEP_BUSY);
        end
        for (cyc = 0; cyc < 40 && STEP_BUSY; cyc++) begin
            clk1();
            if (TICK[0]) begin
                if (lastAt >= 0 && cyc - lastAt != 3) gapBad++;
                lastAt = cyc;
                pulses++;
            end
            vectors++;
            if ({STEP_BUSY, TICK, SIM_CLK} !== {mBusy, mTick, mSim}) begin
                miscompares++;
                $display("FAIL step_cycle cyc=%0d got=%h want=%h", cyc, {STEP_BUSY, TICK, SIM_CLK},
                         {mBusy, mTick, mSim});
            end
        end
        vectors++;
        if (pulses !== 5 || gapBad !== 0 || STEP_BUSY !== 1'b0 || TICK[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL step_burst pulses=%0d gapBad=%0d busy=%b lastTick=%b want 5/0/0/1",
                     pulses, gapBad, STEP_BUSY, TICK[0]);
        end
        for (int k = 0; k < 6; k++) begin
            clk1();
            vectors++;
            if (TICK !== 4'd0 || {SIM_CLK, STEP_BUSY} !== {mSim, mBusy}) begin
                miscompares++;
                $display("FAIL step_frozen got=%h want=%h", {TICK, SIM_CLK, STEP_BUSY}, {4'd0, mSim, mBusy});
            end
        end
    endtask

    task automatic test_step_zero();
        STEP_REQ = 1'b1; STEP_COUNT = 8'd0;
        clk1();
        STEP_REQ = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clk1();
            vectors++;
            if (STEP_BUSY !== 1'b0 || TICK !== 4'd0 || LED !== {5'b0, mRunQ, mBusy, mSim[0]}) begin
                miscompares++;
                $display("FAIL step_zero busy=%b tick=%h led=%h want 0/0/%h", STEP_BUSY, TICK, LED,
                         {5'b0, mRunQ, mBusy, mSim[0]});
            end
        end
    endtask

    task automatic test_abort_and_reset();
        int seen = 0;
        int cyc;
        STEP_REQ = 1'b1; STEP_COUNT = 8'd10;
        clk1();
        STEP_REQ = 1'b0;
        for (cyc = 0; cyc < 40 && seen < 3; cyc++) begin
            clk1();
            if (TICK[0]) seen++;
        end
        vectors++;
        if (seen !== 3 || STEP_BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_prefix ticks=%0d busy=%b want 3/1", seen, STEP_BUSY);
        end
        RUN_EN = 1'b1;
        for (int k = 0; k < 14; k++) begin
            clk1();
            vectors++;
            if (STEP_BUSY !== 1'b0 || {TICK, SIM_CLK, LED} !== {mTick, mSim, 5'b0, mRunQ, mBusy, mSim[0]}) begin
                miscompares++;
                $display("FAIL abort_run k=%0d got=%h want=%h", k, {STEP_BUSY, TICK, SIM_CLK, LED},
                         {1'b0, mTick, mSim, 5'b0, mRunQ, mBusy, mSim[0]});
            end
        end
        RST = 1'b1;
        clk1();
        vectors++;
        if ({STEP_BUSY, TICK, SIM_CLK, LED} !== 17'd0) begin
            miscompares++;
            $display("FAIL midrun_reset got=%h want=0", {STEP_BUSY, TICK, SIM_CLK, LED});
        end
        RST = 1'b0;
        RUN_EN = 1'b0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            RST      = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) RUN_EN = ~RUN_EN;
            CFG_WE   = ($urandom_range(0, 11) == 0);
            CFG_CH   = 2'($urandom_range(0, 3));
            CFG_DIV  = 16'($urandom_range(0, 5));
            STEP_REQ = ($urandom_range(0, 7) == 0);
            STEP_COUNT = 8'($urandom_range(0, 6));
            clk1();
            vectors++;
            if ({STEP_BUSY, TICK, SIM_CLK, LED} !== {mBusy, mTick, mSim, 5'b0, mRunQ, mBusy, mSim[0]}) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, {STEP_BUSY, TICK, SIM_CLK, LED},
                         {mBusy, mTick, mSim, 5'b0, mRunQ, mBusy, mSim[0]});
            end
`ifdef SIM_TICK_CNT_EN
            vectors++;
            if (TICK_CNT !== mTickCnt) begin
                miscompares++;
                $display("FAIL random_tick_cnt cyc=%0d got=%0d want=%0d", cyc, TICK_CNT, mTickCnt);
            end
`endif
        end
        RST = 1'b0; CFG_WE = 1'b0; STEP_REQ = 1'b0; RUN_EN = 1'b0;
    endtask

`ifdef SIM_TICK_CNT_EN
    task automatic test_tick_cnt();
        RST = 1'b1; RUN_EN = 1'b0;
        clk1();
        RST = 1'b0;
        CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_DIV = 16'd2;
        clk1();
        CFG_WE = 1'b0;
        RUN_EN = 1'b1;
        repeat (21) clk1();
        vectors++;
        if (TICK_CNT !== 32'd10 || TICK_CNT !== mTickCnt) begin
            miscompares++;
            $display("FAIL tick_cnt got=%0d want=10 model=%0d", TICK_CNT, mTickCnt);
        end
        RUN_EN = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_freerun();
        test_cfg_div();
        test_step();
        test_step_zero();
        test_abort_and_reset();
        test_random();
`ifdef SIM_TICK_CNT_EN
        test_tick_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sim_tick_gen.md
Name: sim_tick_gen

Overview:
- Parametrised, multi-channel programmable tick generator for the HIL simulation core. It supersedes the fixed single-output simulation clock divider.
- Each channel divides CLK_50MHZ by a run-time-programmable ratio. It produces a one-cycle TICK strobe and a toggling SIM_CLK.
- A control FSM supports free-run, freeze and counted single-step bursts, so the host can advance the simulation a known number of ticks.
- Outputs drive simulation model enables and the board LEDs.

Parameters:
- NUM_CH, 4, number of tick channels (1..8).
- DIV_W, 16, width of each channel's divide-ratio register and counter.
- DIV_RESET, 50000, divide ratio loaded into every channel at reset (1 kHz at 50 MHz).
- STEP_W, 8, width of the step-burst count.

Ports:
- CLK_50MHZ  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- RUN_EN  in  1  level: free-run all channels while high.
- CFG_WE  in  1  one-cycle write strobe for a channel divide ratio.
- CFG_CH  in  clog2(NUM_CH) (min 1)  channel index for CFG_WE.
- CFG_DIV  in  DIV_W  new divide ratio.
- STEP_REQ  in  1  one-cycle request to start a step burst.
- STEP_COUNT  in  STEP_W  number of channel-0 ticks in the burst; sampled with STEP_REQ.
- STEP_BUSY  out  1  high while a step burst is in progress.
- TICK  out  NUM_CH  per-channel one-cycle strobe.
- SIM_CLK  out  NUM_CH  per-channel 50%-ish square wave; toggles on each tick.
- LED  out  8  bit 0 = SIM_CLK[0], bit 1 = STEP_BUSY, bit 2 = RUN_EN state, bits 7:3 = 0.

Behaviour:
- One clock, CLK_50MHZ. Reset is synchronous and active-high (RST), sampled on the rising edge of CLK_50MHZ.
- Reset values:
  - all counters 0; all div registers = DIV_RESET
  - TICK = 0, SIM_CLK = 0, STEP_BUSY = 0, LED = 0
  - FSM = IDLE, step remaining count = 0
- RST mid-burst aborts the burst with no further ticks.
- Effective divide: div_eff = (div == 0) ? 1 : div.
- Channel counting, for each enabled cycle and each channel i:
  - if cnt[i] == div_eff-1: cnt <= 0, TICK[i] <= 1, SIM_CLK[i] <= ~SIM_CLK[i]
  - else: cnt <= cnt+1, TICK[i] <= 0
  - Tick period = div_eff cycles. The first TICK is registered at the div_eff-th enabled edge.
- Disabled cycles: counters and SIM_CLK hold, TICK = 0.
- Config write (CFG_WE): div[CFG_CH] <= CFG_DIV and cnt[CFG_CH] <= 0 on that edge. That channel emits no TICK that cycle. Other channels are unaffected. CFG_CH >= NUM_CH is ignored.
- FSM states:
  - IDLE: enable = 0. RUN_EN=1 -> RUN. Else STEP_REQ=1 with STEP_COUNT != 0 -> STEP, remaining <= STEP_COUNT. STEP_REQ with count 0 is ignored.
  - RUN: enable = 1. RUN_EN=0 -> IDLE; counters freeze and resume seamlessly on the next run. STEP_REQ is ignored.
  - STEP: enable = 1, STEP_BUSY = 1. Each channel-0 tick decrements remaining. When the tick that makes remaining reach 0 is generated, next state = IDLE.
  - STEP exit: STEP_BUSY drops in the same cycle that final TICK[0] is high. Other channels tick only as their counters allow during the burst.
  - STEP with RUN_EN=1 -> RUN: burst aborted, remaining cleared. Further STEP_REQ during STEP is ignored.
- Simultaneous events:
  - RUN_EN has priority over STEP_REQ in IDLE.
  - A CFG_WE colliding with a terminal count wins: counter cleared, no tick.
  - If that channel is 0 in STEP, remaining is not decremented.
- Counter widths are DIV_W; no overflow is possible because cnt < div_eff <= 2^DIV_W-1.

Optional Feature:
- Macro: SIM_TICK_CNT_EN.
- Defined:
  - Adds output TICK_CNT [31:0], a free-running count of channel-0 ticks that wraps at 2^32.
  - Reset to 0 by RST; unaffected by CFG_WE.
  - Increments in the same cycle TICK[0] is high.
- Undefined: the port is absent and no counter logic is generated.

Test Plan:
- Reset with DIV_RESET=4, RUN_EN=1 from cycle 0 -> TICK[0..3] high every 4th cycle, first at cycle 4 after reset release; SIM_CLK period 8 cycles; LED[0] tracks SIM_CLK[0].
- CFG_WE ch1 CFG_DIV=0, then ch2 CFG_DIV=1, with RUN_EN=1 -> TICK[1] and TICK[2] high every enabled cycle; ch1 counter restarts on the write edge; ch0/ch3 cadence undisturbed.
- IDLE, div0=3, STEP_REQ with STEP_COUNT=5 -> exactly 5 TICK[0] pulses, 3 cycles apart; STEP_BUSY high from the next edge until the cycle of the 5th tick, then IDLE with counters frozen.
- STEP_REQ with STEP_COUNT=0 -> no state change, STEP_BUSY stays 0, no ticks.
- During a 10-tick burst assert RUN_EN after tick 3 -> burst aborted, free-run continues with no phase glitch, STEP_BUSY=0; assert RST mid-run -> all outputs 0 on the next edge.
- With SIM_TICK_CNT_EN defined and div0=2, run 20 cycles -> TICK_CNT=10. With the macro undefined, the bench must compile without the port.
